// File: rtl/window_event_counter_pkg.sv
// Shared types and helpers for the windowed event-rate counter.
// The sample record is declared in the modules because its width follows WIDTH.
package window_event_counter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // ovf, udf and partial ride alongside the count in every sample
   localparam int unsigned FLAG_BITS = 3;

   function automatic int unsigned timer_width(input int unsigned window);
      return (window > 2) ? $clog2(window) : 1;
   endfunction

endpackage

// File: rtl/window_event_counter_sample_fifo.sv
// Two-entry in-order sample buffer with valid/ready output.
// A push while full is only taken when the same cycle pops.
module sample_fifo
   import window_event_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH+FLAG_BITS-1:0] push_data,
   output logic                       full,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic [WIDTH+FLAG_BITS-1:0] o_data
);

   localparam int unsigned DW = WIDTH + FLAG_BITS;

   logic [DW-1:0] mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    level;
   logic          pop;
   logic          wr_en;

   assign full    = (level == 2'd2);
   assign o_valid = (level != 2'd0);
   assign pop     = o_valid && o_ready;
   assign wr_en   = push && (!full || pop);
   assign o_data  = o_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         level  <= 2'd0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   level <= level + 2'd1;
            2'b01:   level <= level - 2'd1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/window_event_counter.sv
// Windowed event-rate counter: saturating net count per WINDOW cycles,
// one sample per window (or per stop) into a 2-entry output buffer.
//
// state | meaning
// IDLE  | cleared, waiting for start_i; strobes and stop_i ignored
// RUN   | counting strobes; sample pushed at window end or on stop_i
module window_event_counter
   import window_event_counter_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned WINDOW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic             busy_o,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_count,
   output logic             o_ovf,
   output logic             o_udf,
   output logic             o_partial,
   output logic             drop_o
);

   localparam int unsigned      TW         = timer_width(WINDOW);
   localparam logic [TW-1:0]    TIMER_LOAD = TW'(WINDOW - 1);
   localparam logic [WIDTH-1:0] ACC_MAX    = '1;

   typedef struct packed {
      logic [WIDTH-1:0] count;
      logic             ovf;
      logic             udf;
      logic             partial;
   } sample_t;

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [WIDTH-1:0] acc_q, acc_d, acc_step;
   logic             ovf_q, ovf_d, ovf_step;
   logic             udf_q, udf_d, udf_step;
   logic             push;
   logic             fifo_full;
   logic             pop;
   logic             drop_d, drop_q;
   sample_t          push_sample;
   sample_t          out_sample;

   // The step includes the current cycle's strobes so a pushed sample sees them.
   always_comb begin
      acc_step = acc_q;
      ovf_step = ovf_q;
      udf_step = udf_q;
      if (inc_i && !dec_i) begin
         if (acc_q == ACC_MAX) ovf_step = 1'b1;
         else                  acc_step = acc_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (acc_q == '0) udf_step = 1'b1;
         else             acc_step = acc_q - 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      udf_d       = udf_q;
      push        = 1'b0;
      push_sample = '0;
      case (state_q)
         IDLE: begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            timer_d = TIMER_LOAD;
            if (start_i) state_d = RUN;
         end
         RUN: begin
            acc_d               = acc_step;
            ovf_d               = ovf_step;
            udf_d               = udf_step;
            timer_d             = timer_q - 1'b1;
            push_sample.count   = acc_step;
            push_sample.ovf     = ovf_step;
            push_sample.udf     = udf_step;
            push_sample.partial = stop_i;
            if (stop_i || (timer_q == '0)) begin
               push    = 1'b1;
               acc_d   = '0;
               ovf_d   = 1'b0;
               udf_d   = 1'b0;
               timer_d = TIMER_LOAD;
               if (stop_i) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= TIMER_LOAD;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         drop_q  <= drop_d;
      end
   end

   // A full buffer still takes the push when the consumer drains it this cycle.
   assign pop    = o_valid && o_ready;
   assign drop_d = push && fifo_full && !pop;

   sample_fifo #(
      .WIDTH (WIDTH)
   ) u_sample_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_sample),
      .full      (fifo_full),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_data    (out_sample)
   );

   assign busy_o    = (state_q == RUN);
   assign drop_o    = drop_q;
   assign o_count   = out_sample.count;
   assign o_ovf     = out_sample.ovf;
   assign o_udf     = out_sample.udf;
   assign o_partial = out_sample.partial;

endmodule
